// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions, FSM states
// and the pass-through control bundle carried down to the ME stage.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_AUIPC  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctrl_t;

endpackage

// File: rtl/exec_if.sv
// ID/EX inputs, ME/WB forwarding taps and EX/ME outputs of the execute stage.
interface exec_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
);
    logic            id_valid;
    logic            flush;
    logic            ex_stall;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            id_alu_src;
    logic [3:0]      id_alu_op;
    logic            id_branch;
    logic [2:0]      id_br_cond;
    logic            id_mul;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            me_fwd_we;
    logic            wb_fwd_we;
    logic [REGW-1:0] me_fwd_rd;
    logic [REGW-1:0] wb_fwd_rd;
    logic [XLEN-1:0] me_fwd_val;
    logic [XLEN-1:0] wb_fwd_val;
    logic            ex_valid;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_rs2;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_branch_taken;
    logic [XLEN-1:0] ex_branch_pc;

    modport master (
        output id_valid, flush, id_rs1_val, id_rs2_val, id_rs1, id_rs2, id_rd,
               id_imm, id_pc, id_alu_src, id_alu_op, id_branch, id_br_cond, id_mul,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               me_fwd_we, wb_fwd_we, me_fwd_rd, wb_fwd_rd, me_fwd_val, wb_fwd_val,
        input  ex_stall, ex_valid, ex_alu_result, ex_rs2, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch_taken, ex_branch_pc
    );

    modport slave (
        input  id_valid, flush, id_rs1_val, id_rs2_val, id_rs1, id_rs2, id_rd,
               id_imm, id_pc, id_alu_src, id_alu_op, id_branch, id_br_cond, id_mul,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               me_fwd_we, wb_fwd_we, me_fwd_rd, wb_fwd_rd, me_fwd_val, wb_fwd_val,
        output ex_stall, ex_valid, ex_alu_result, ex_rs2, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch_taken, ex_branch_pc
    );
endinterface

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per busy cycle, low XLEN bits kept.
module exec_mul_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done_c,
    output logic [XLEN-1:0] product_c
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_nxt_c;

    // Product is presented combinationally during the last busy cycle so the
    // EX/ME register captures it on the same edge the FSM returns to idle.
    assign acc_nxt_c = acc + (mplier[0] ? mcand : '0);
    assign done_c    = busy && (cnt == CW'(XLEN - 1));
    assign product_c = acc_nxt_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done_c) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Pipelined execute stage: operand forwarding, ALU, branch resolve and an
// iterative multiplier that stalls ID while it runs. All outputs registered.
module exec_stage
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic  clk,
    input  logic  reset_n,
    exec_if.slave bus
);
    localparam int unsigned SHW     = $clog2(XLEN);
    localparam logic [0:0]  ST_IDLE = 1'(IDLE);
    localparam logic [0:0]  ST_BUSY = 1'(BUSY);

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic            accept_c;
    logic            mul_start_c;
    logic            mul_busy;
    logic            mul_done_c;
    logic            br_hit_c;
    logic            taken_c;
    logic [SHW-1:0]  shamt_c;
    logic [XLEN-1:0] op_a_c;
    logic [XLEN-1:0] rs2_fwd_c;
    logic [XLEN-1:0] op_b_c;
    logic [XLEN-1:0] alu_c;
    logic [XLEN-1:0] mul_prod_c;
    ex_ctrl_t        id_ctrl_c;
    ex_ctrl_t        mul_ctrl;
    ex_ctrl_t        ex_ctrl;
    logic [REGW-1:0] mul_rd;

    assign accept_c  = bus.id_valid && !bus.flush && (state == ST_IDLE) && !mul_busy;
    assign id_ctrl_c = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg};

    // Forwarding: ME beats WB, x0 never forwarded.
    always_comb begin
        op_a_c    = bus.id_rs1_val;
        rs2_fwd_c = bus.id_rs2_val;
        if (bus.id_rs1 != '0 && bus.me_fwd_we && bus.me_fwd_rd == bus.id_rs1)
            op_a_c = bus.me_fwd_val;
        else if (bus.id_rs1 != '0 && bus.wb_fwd_we && bus.wb_fwd_rd == bus.id_rs1)
            op_a_c = bus.wb_fwd_val;
        if (bus.id_rs2 != '0 && bus.me_fwd_we && bus.me_fwd_rd == bus.id_rs2)
            rs2_fwd_c = bus.me_fwd_val;
        else if (bus.id_rs2 != '0 && bus.wb_fwd_we && bus.wb_fwd_rd == bus.id_rs2)
            rs2_fwd_c = bus.wb_fwd_val;
    end

    assign op_b_c  = bus.id_alu_src ? bus.id_imm : rs2_fwd_c;
    assign shamt_c = op_b_c[SHW-1:0];

    always_comb begin
        alu_c = '0;
        case (bus.id_alu_op)
            ALU_ADD:    alu_c = op_a_c + op_b_c;
            ALU_SUB:    alu_c = op_a_c - op_b_c;
            ALU_AND:    alu_c = op_a_c & op_b_c;
            ALU_OR:     alu_c = op_a_c | op_b_c;
            ALU_XOR:    alu_c = op_a_c ^ op_b_c;
            ALU_SLL:    alu_c = op_a_c << shamt_c;
            ALU_SRL:    alu_c = op_a_c >> shamt_c;
            ALU_SRA:    alu_c = $unsigned($signed(op_a_c) >>> shamt_c);
            ALU_SLT:    alu_c = XLEN'($signed(op_a_c) < $signed(op_b_c));
            ALU_SLTU:   alu_c = XLEN'(op_a_c < op_b_c);
            ALU_PASS_B: alu_c = op_b_c;
            ALU_AUIPC:  alu_c = bus.id_pc + op_b_c;
            default:    alu_c = '0;
        endcase
    end

    // Branches always compare the forwarded registers, regardless of alu_src.
    always_comb begin
        br_hit_c = 1'b0;
        case (bus.id_br_cond)
            BR_EQ:   br_hit_c = (op_a_c == rs2_fwd_c);
            BR_NE:   br_hit_c = (op_a_c != rs2_fwd_c);
            BR_LT:   br_hit_c = ($signed(op_a_c) <  $signed(rs2_fwd_c));
            BR_GE:   br_hit_c = ($signed(op_a_c) >= $signed(rs2_fwd_c));
            BR_LTU:  br_hit_c = (op_a_c <  rs2_fwd_c);
            BR_GEU:  br_hit_c = (op_a_c >= rs2_fwd_c);
            default: br_hit_c = 1'b0;
        endcase
    end

    assign taken_c = accept_c && !bus.id_mul && bus.id_branch && br_hit_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mul_start_c = 1'b0;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept_c && bus.id_mul) begin
                    state_nxt   = ST_BUSY;
                    mul_start_c = 1'b1;
                end
                ST_BUSY: if (mul_done_c) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.ex_stall = (state == ST_BUSY);

    exec_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (mul_start_c),
        .abort     (bus.flush),
        .a         (op_a_c),
        .b         (rs2_fwd_c),
        .busy      (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_prod_c)
    );

    // Destination and control of the multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_rd   <= '0;
            mul_ctrl <= '0;
        end else if (accept_c && bus.id_mul) begin
            mul_rd   <= bus.id_rd;
            mul_ctrl <= id_ctrl_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ex_valid        <= 1'b0;
            bus.ex_alu_result   <= '0;
            bus.ex_rs2          <= '0;
            bus.ex_rd           <= '0;
            ex_ctrl             <= '0;
            bus.ex_branch_taken <= 1'b0;
            bus.ex_branch_pc    <= '0;
        end else begin
            bus.ex_valid        <= 1'b0;
            ex_ctrl             <= '0;
            bus.ex_branch_taken <= taken_c;
            bus.ex_branch_pc    <= taken_c ? (bus.id_pc + bus.id_imm) : '0;
            if (!bus.flush && mul_done_c) begin
                bus.ex_valid      <= 1'b1;
                bus.ex_alu_result <= mul_prod_c;
                bus.ex_rd         <= mul_rd;
                ex_ctrl           <= mul_ctrl;
            end else if (accept_c && !bus.id_mul) begin
                bus.ex_valid      <= 1'b1;
                bus.ex_alu_result <= alu_c;
                bus.ex_rs2        <= rs2_fwd_c;
                bus.ex_rd         <= bus.id_rd;
                ex_ctrl           <= id_ctrl_c;
            end
        end
    end

    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the stage.
module tb_exec_stage;
    import exec_pkg::*;

    logic clk;
    logic reset_n;

    exec_if #(.XLEN(32), .REGW(5)) bus ();
    exec_if #(.XLEN(16), .REGW(5)) bus16 ();

    exec_stage #(.XLEN(32), .REGW(5)) dut   (.clk(clk), .reset_n(reset_n), .bus(bus));
    exec_stage #(.XLEN(16), .REGW(5)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        exp_valid, exp_stall, exp_taken;
    logic [31:0] exp_result, exp_rs2, exp_bpc, pend_prod;
    logic [4:0]  exp_rd, pend_rd;
    logic [3:0]  exp_ctrl, pend_ctrl;
    int          busy_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (bus.me_fwd_we && bus.me_fwd_rd == rs) return bus.me_fwd_val;
        if (bus.wb_fwd_we && bus.wb_fwd_rd == rs) return bus.wb_fwd_val;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:    return {31'b0, ($signed(a) < $signed(b))};
            4'd9:    return {31'b0, (a < b)};
            4'd10:   return b;
            4'd11:   return pc + b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return !($signed(a) < $signed(b));
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[31:0];
    endfunction

    task automatic model_reset();
        exp_valid = 0; exp_stall = 0; exp_taken = 0;
        exp_result = '0; exp_rs2 = '0; exp_bpc = '0; exp_rd = '0; exp_ctrl = '0;
        pend_prod = '0; pend_rd = '0; pend_ctrl = '0; busy_left = 0;
    endtask

    // Predict EX/ME contents after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [31:0] a, b;
        exp_valid = 0; exp_ctrl = '0; exp_taken = 0; exp_bpc = '0;
        if (bus.flush) begin
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                exp_valid = 1; exp_result = pend_prod; exp_rd = pend_rd; exp_ctrl = pend_ctrl;
            end
        end else if (bus.id_valid) begin
            a = fwd_ref(bus.id_rs1, bus.id_rs1_val);
            b = fwd_ref(bus.id_rs2, bus.id_rs2_val);
            if (bus.id_mul) begin
                busy_left = 32;
                pend_prod = mul_ref(a, b);
                pend_rd   = bus.id_rd;
                pend_ctrl = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg};
            end else begin
                exp_valid  = 1;
                exp_result = alu_ref(bus.id_alu_op, a, bus.id_alu_src ? bus.id_imm : b, bus.id_pc);
                exp_rs2    = b;
                exp_rd     = bus.id_rd;
                exp_ctrl   = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg};
                if (bus.id_branch && br_ref(bus.id_br_cond, a, b)) begin
                    exp_taken = 1;
                    exp_bpc   = bus.id_pc + bus.id_imm;
                end
            end
        end
        exp_stall = (busy_left > 0);
    endtask

    task automatic compare_all();
        check("valid",  64'(bus.ex_valid), 64'(exp_valid));
        check("stall",  64'(bus.ex_stall), 64'(exp_stall));
        check("result", 64'(bus.ex_alu_result), 64'(exp_result));
        check("rs2",    64'(bus.ex_rs2), 64'(exp_rs2));
        check("rd",     64'(bus.ex_rd), 64'(exp_rd));
        check("ctrl",   64'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
                        64'(exp_ctrl));
        check("taken",  64'(bus.ex_branch_taken), 64'(exp_taken));
        check("br_pc",  64'(bus.ex_branch_pc), 64'(exp_bpc));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_nop();
        bus.id_valid = 0; bus.flush = 0;
        bus.id_rs1_val = '0; bus.id_rs2_val = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
        bus.id_imm = '0; bus.id_pc = '0; bus.id_alu_src = 0; bus.id_alu_op = '0;
        bus.id_branch = 0; bus.id_br_cond = '0; bus.id_mul = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0;
        bus.me_fwd_we = 0; bus.wb_fwd_we = 0; bus.me_fwd_rd = '0; bus.wb_fwd_rd = '0;
        bus.me_fwd_val = '0; bus.wb_fwd_val = '0;
    endtask

    task automatic set_nop16();
        bus16.id_valid = 0; bus16.flush = 0;
        bus16.id_rs1_val = '0; bus16.id_rs2_val = '0; bus16.id_rs1 = '0; bus16.id_rs2 = '0;
        bus16.id_rd = '0; bus16.id_imm = '0; bus16.id_pc = '0; bus16.id_alu_src = 0;
        bus16.id_alu_op = '0; bus16.id_branch = 0; bus16.id_br_cond = '0; bus16.id_mul = 0;
        bus16.id_reg_write = 0; bus16.id_mem_read = 0; bus16.id_mem_write = 0; bus16.id_mem_to_reg = 0;
        bus16.me_fwd_we = 0; bus16.wb_fwd_we = 0; bus16.me_fwd_rd = '0; bus16.wb_fwd_rd = '0;
        bus16.me_fwd_val = '0; bus16.wb_fwd_val = '0;
    endtask

    task automatic rand_inputs();
        bus.id_valid      = ($urandom_range(0, 9) < 8);
        bus.flush         = ($urandom_range(0, 19) == 0);
        bus.id_rs1        = 5'($urandom_range(0, 7));
        bus.id_rs2        = 5'($urandom_range(0, 7));
        bus.id_rd         = 5'($urandom_range(0, 31));
        bus.id_rs1_val    = $urandom();
        bus.id_rs2_val    = ($urandom_range(0, 3) == 0) ? bus.id_rs1_val : $urandom();
        bus.id_imm        = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom();
        bus.id_pc         = $urandom();
        bus.id_alu_src    = 1'($urandom_range(0, 1));
        bus.id_alu_op     = 4'($urandom_range(0, 15));
        bus.id_branch     = ($urandom_range(0, 3) == 0);
        bus.id_br_cond    = 3'($urandom_range(0, 7));
        bus.id_mul        = ($urandom_range(0, 15) == 0);
        bus.id_reg_write  = 1'($urandom_range(0, 1));
        bus.id_mem_read   = 1'($urandom_range(0, 1));
        bus.id_mem_write  = 1'($urandom_range(0, 1));
        bus.id_mem_to_reg = 1'($urandom_range(0, 1));
        bus.me_fwd_we     = 1'($urandom_range(0, 1));
        bus.wb_fwd_we     = 1'($urandom_range(0, 1));
        bus.me_fwd_rd     = 5'($urandom_range(0, 7));
        bus.wb_fwd_rd     = 5'($urandom_range(0, 7));
        bus.me_fwd_val    = $urandom();
        bus.wb_fwd_val    = $urandom();
    endtask

    logic [2:0] br_conds [5] = '{3'b100, 3'b110, 3'b111, 3'b001, 3'b010};
    logic       br_exp   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int n;
        reset_n = 0;
        set_nop();
        set_nop16();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 reset_n = 1;

        // Forwarding priority
        bus.id_valid = 1; bus.id_rs1 = 5'd5; bus.id_rs1_val = 32'h30;
        bus.id_alu_src = 1; bus.id_imm = 32'h1; bus.id_alu_op = ALU_ADD;
        bus.me_fwd_we = 1; bus.me_fwd_rd = 5'd5; bus.me_fwd_val = 32'h10;
        bus.wb_fwd_we = 1; bus.wb_fwd_rd = 5'd5; bus.wb_fwd_val = 32'h20;
        step(); check("fwd_me", 64'(bus.ex_alu_result), 64'h11);
        bus.me_fwd_we = 0;
        step(); check("fwd_wb", 64'(bus.ex_alu_result), 64'h21);
        bus.me_fwd_we = 1; bus.me_fwd_rd = 5'd0; bus.wb_fwd_rd = 5'd0;
        step(); check("fwd_rf", 64'(bus.ex_alu_result), 64'h31);

        // Branch conditions and target wrap
        set_nop();
        bus.id_valid = 1; bus.id_branch = 1; bus.id_alu_op = ALU_SUB;
        bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rs1_val = 32'hFFFF_FFFF; bus.id_rs2_val = 32'h1;
        bus.id_pc = 32'hFFFF_FFF0; bus.id_imm = 32'h20;
        for (int i = 0; i < 5; i++) begin
            bus.id_br_cond = br_conds[i];
            step();
            check("br_dir", 64'(bus.ex_branch_taken), 64'(br_exp[i]));
            check("br_tgt", 64'(bus.ex_branch_pc), br_exp[i] ? 64'h10 : 64'h0);
        end
        bus.id_valid = 0;
        step(); check("br_pulse", 64'(bus.ex_branch_taken), 64'h0);

        // Multiply with a held ADD behind it
        set_nop();
        bus.id_valid = 1; bus.id_mul = 1; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_rd = 5'd9;
        bus.id_rs1_val = 32'hFFFF_FFFF; bus.id_rs2_val = 32'h3;
        step();
        bus.id_mul = 0; bus.id_alu_op = ALU_ADD; bus.id_rs1_val = 32'h1; bus.id_rs2_val = 32'h2;
        bus.id_rd = 5'd4;
        n = 0;
        while (bus.ex_stall && n < 40) begin
            n++;
            step();
        end
        check("mul_stall_cycles", 64'(n), 64'd32);
        check("mul_valid", 64'(bus.ex_valid), 64'h1);
        check("mul_product", 64'(bus.ex_alu_result), 64'hFFFF_FFFD);
        check("mul_rd", 64'(bus.ex_rd), 64'd9);
        step();
        check("held_add", 64'(bus.ex_alu_result), 64'h3);
        check("held_valid", 64'(bus.ex_valid), 64'h1);

        // Flush while busy: no product, stall drops
        set_nop();
        bus.id_valid = 1; bus.id_mul = 1; bus.id_rs1_val = 32'h5; bus.id_rs2_val = 32'h5;
        step();
        bus.id_valid = 0; bus.id_mul = 0;
        repeat (5) step();
        bus.flush = 1;
        step(); check("flush_stall", 64'(bus.ex_stall), 64'h0);
        bus.flush = 0;
        for (int i = 0; i < 35; i++) begin
            step(); check("flush_noresult", 64'(bus.ex_valid), 64'h0);
        end

        // Flush with a taken BEQ presented
        set_nop();
        bus.id_valid = 1; bus.id_branch = 1; bus.id_br_cond = 3'b000; bus.flush = 1;
        bus.id_rs1_val = 32'h5; bus.id_rs2_val = 32'h5; bus.id_imm = 32'h40;
        step(); check("flush_br", 64'(bus.ex_branch_taken), 64'h0);

        // SRA with over-wide amount, unused opcode
        set_nop();
        bus.id_valid = 1; bus.id_alu_src = 1; bus.id_rs1_val = 32'h8000_0000; bus.id_imm = 32'h21;
        bus.id_alu_op = ALU_SRA;
        step(); check("sra", 64'(bus.ex_alu_result), 64'hC000_0000);
        bus.id_alu_op = 4'd13;
        step(); check("op13", 64'(bus.ex_alu_result), 64'h0);

        // Reset in the middle of a multiply
        set_nop();
        bus.id_valid = 1; bus.id_mul = 1; bus.id_rs1_val = 32'd7; bus.id_rs2_val = 32'd6;
        step();
        bus.id_valid = 0; bus.id_mul = 0;
        repeat (9) step();
        #2 reset_n = 0;
        model_reset();
        #1;
        compare_all();
        check("rst_stall", 64'(bus.ex_stall), 64'h0);
        #1 reset_n = 1;
        bus.id_valid = 1; bus.id_alu_src = 1; bus.id_rs1_val = 32'h1; bus.id_imm = 32'h1;
        bus.id_alu_op = ALU_ADD;
        step(); check("post_rst_add", 64'(bus.ex_alu_result), 64'h2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        // XLEN=16 wrap
        bus16.id_valid = 1; bus16.id_alu_src = 1; bus16.id_rs1_val = 16'hFFFF; bus16.id_imm = 16'h1;
        bus16.id_alu_op = ALU_ADD;
        @(posedge clk);
        #1;
        check("x16_add", 64'(bus16.ex_alu_result), 64'h0);
        check("x16_valid", 64'(bus16.ex_valid), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
